// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: 68000 target-side responder for a four-word register window.
// Qualifies the synchronized AS/DS strobes, counts MC-clock falls, then drives DTACK and read data.
module m68k_bus_responder #(
  parameter logic [22:0] BASE_ADDR   = 23'h7C0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        SYSCLK,
  input  logic        RESET_N,
  input  logic        MCCLK_FALLING,
  input  logic        MCCLK_RISING,
  input  logic        AS_N,
  input  logic        UDS_N,
  input  logic        LDS_N,
  input  logic        RW,
  input  logic [22:0] ADDR,
  input  logic [15:0] DATA_IN,
  input  logic [15:0] STATUS_IN,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  output logic        DTACK_N,
  output logic        DTACK_OE,
  output logic [47:0] REGS
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IGNORE,
    S_WAIT,
    S_ACK,
    S_RELEASE
  } state_t;

  state_t      state;
  logic [1:0]  as_sync;
  logic [1:0]  uds_sync;
  logic [1:0]  lds_sync;
  logic [3:0]  cnt;
  logic [1:0]  idx;
  logic        rd;
  logic        upper_en;
  logic        lower_en;
  logic [15:0] r0;
  logic [15:0] r1;
  logic [15:0] r2;

  logic as_high;
  logic ds_act;
  logic in_window;
  logic unused_rising;

  assign as_high       = as_sync[1];
  assign ds_act        = !uds_sync[1] || !lds_sync[1];
  assign in_window     = (ADDR[22:2] == BASE_ADDR[22:2]);
  assign unused_rising = MCCLK_RISING;
  assign REGS          = {r2, r1, r0};

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_val,
                                              input logic [15:0] new_val,
                                              input logic        upper,
                                              input logic        lower);
    logic [15:0] result;
    result = old_val;
    if (upper) result[15:8] = new_val[15:8];
    if (lower) result[7:0]  = new_val[7:0];
    return result;
  endfunction

  // Stage [1] of each synchronizer is the settled value; both stages reset negated.
  always_ff @(negedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      as_sync  <= 2'b11;
      uds_sync <= 2'b11;
      lds_sync <= 2'b11;
    end else begin
      as_sync  <= {as_sync[0], AS_N};
      uds_sync <= {uds_sync[0], UDS_N};
      lds_sync <= {lds_sync[0], LDS_N};
    end
  end

  always_ff @(negedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      idx      <= 2'd0;
      rd       <= 1'b0;
      upper_en <= 1'b0;
      lower_en <= 1'b0;
      r0       <= 16'h0000;
      r1       <= 16'h0000;
      r2       <= 16'h0000;
      DATA_OUT <= 16'h0000;
      DATA_OE  <= 1'b0;
      DTACK_N  <= 1'b1;
      DTACK_OE <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!as_high && in_window && ds_act) begin
            idx      <= ADDR[1:0];
            rd       <= RW;
            upper_en <= !uds_sync[1];
            lower_en <= !lds_sync[1];
            cnt      <= WAIT_INIT;
            state    <= S_WAIT;
          end else if (!as_high && !in_window) begin
            state <= S_IGNORE;
          end
        end

        S_IGNORE: begin
          if (as_high) state <= S_IDLE;
        end

        // An abort takes priority over a coincident MC-clock falling strobe.
        S_WAIT: begin
          if (as_high) begin
            state <= S_IDLE;
          end else if (MCCLK_FALLING) begin
            if (cnt == 4'd0) begin
              state    <= S_ACK;
              DTACK_N  <= 1'b0;
              DTACK_OE <= 1'b1;
              DATA_OE  <= rd;
              if (rd) begin
                case (idx)
                  2'd0:    DATA_OUT <= r0;
                  2'd1:    DATA_OUT <= r1;
                  2'd2:    DATA_OUT <= r2;
                  default: DATA_OUT <= STATUS_IN;
                endcase
              end else begin
                case (idx)
                  2'd0:    r0 <= merge_bytes(r0, DATA_IN, upper_en, lower_en);
                  2'd1:    r1 <= merge_bytes(r1, DATA_IN, upper_en, lower_en);
                  2'd2:    r2 <= merge_bytes(r2, DATA_IN, upper_en, lower_en);
                  default: ;
                endcase
              end
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end

        // DTACK is driven high for one cycle before the pin is tristated.
        S_ACK: begin
          if (as_high) begin
            state    <= S_RELEASE;
            DTACK_N  <= 1'b1;
            DTACK_OE <= 1'b1;
            DATA_OE  <= 1'b0;
          end
        end

        S_RELEASE: begin
          state    <= S_IDLE;
          DTACK_N  <= 1'b1;
          DTACK_OE <= 1'b0;
          DATA_OE  <= 1'b0;
        end

        default: begin
          state    <= S_IDLE;
          DTACK_N  <= 1'b1;
          DTACK_OE <= 1'b0;
          DATA_OE  <= 1'b0;
        end
      endcase
    end
  end

endmodule
